// File: rtl/accum_adder_fifo_if.sv
// Handshake bundle for accum_adder_fifo: operand input channel, result
// output channel and the occupancy / accumulator status outputs.
interface accum_adder_fifo_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int DEPTH     = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         a;
    logic [WIDTH-1:0]         b;
    logic [1:0]               mode;
    logic                     out_valid;
    logic                     out_ready;
    logic [ACC_WIDTH-1:0]     result;
    logic                     ovf;
    logic [$clog2(DEPTH):0]   count;
    logic [ACC_WIDTH-1:0]     acc;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, result, ovf, count, acc
    );

    // The adder/FIFO block itself.
    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, result, ovf, count, acc
    );
endinterface

// File: rtl/accum_adder_fifo.sv
// Operand adder with wrap / saturate / accumulate / clear modes feeding a
// DEPTH-entry circular result FIFO. Results are computed at the accepting
// edge and stored; the FIFO head is read straight from storage.
module accum_adder_fifo #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int DEPTH     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    accum_adder_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ACC_WIDTH-1:0] acc_r;
    logic [ACC_WIDTH-1:0] mem_result_r [DEPTH];
    logic                 mem_ovf_r    [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;

    logic                 in_ready_s;
    logic                 out_valid_s;
    logic                 push_s;
    logic                 pop_s;
    logic [WIDTH:0]       sum_s;
    logic [ACC_WIDTH:0]   acc_sum_s;
    logic [ACC_WIDTH-1:0] new_result_s;
    logic [ACC_WIDTH-1:0] acc_next_s;
    logic                 new_ovf_s;

    // Full blocks the input regardless of a same-cycle pop.
    assign in_ready_s  = (count_r != CNT_W'(DEPTH));
    assign out_valid_s = (count_r != {CNT_W{1'b0}});
    assign push_s      = bus.in_valid & in_ready_s;
    assign pop_s       = out_valid_s & bus.out_ready;

    assign sum_s     = {1'b0, bus.a} + {1'b0, bus.b};
    assign acc_sum_s = {1'b0, acc_r} + (ACC_WIDTH+1)'(sum_s);

    // Result, overflow flag and next accumulator for the current operands.
    always_comb begin
        new_result_s = ACC_WIDTH'(sum_s);
        new_ovf_s    = sum_s[WIDTH];
        acc_next_s   = acc_r;
        case (bus.mode)
            2'b00: begin
                new_result_s = ACC_WIDTH'(sum_s);
                new_ovf_s    = sum_s[WIDTH];
            end
            2'b01: begin
                if (sum_s[WIDTH]) begin
                    new_result_s = ACC_WIDTH'({WIDTH{1'b1}});
                end else begin
                    new_result_s = ACC_WIDTH'(sum_s);
                end
                new_ovf_s = sum_s[WIDTH];
            end
            2'b10: begin
                acc_next_s   = acc_sum_s[ACC_WIDTH-1:0];
                new_result_s = acc_sum_s[ACC_WIDTH-1:0];
                new_ovf_s    = acc_sum_s[ACC_WIDTH];
            end
            2'b11: begin
                acc_next_s   = {ACC_WIDTH{1'b0}};
                new_result_s = {ACC_WIDTH{1'b0}};
                new_ovf_s    = 1'b0;
            end
            default: begin
                new_result_s = ACC_WIDTH'(sum_s);
                new_ovf_s    = sum_s[WIDTH];
            end
        endcase
    end

    // Pointers, occupancy and accumulator; reset discards buffered entries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r    <= {ACC_WIDTH{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                acc_r    <= acc_next_s;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (rst_n && push_s) begin
            mem_result_r[wr_ptr_r] <= new_result_s;
            mem_ovf_r[wr_ptr_r]    <= new_ovf_s;
        end
    end

    // Head is forced to zero while empty so reset leaves result/ovf at 0.
    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.result    = out_valid_s ? mem_result_r[rd_ptr_r] : {ACC_WIDTH{1'b0}};
    assign bus.ovf       = out_valid_s & mem_ovf_r[rd_ptr_r];
    assign bus.count     = count_r;
    assign bus.acc       = acc_r;

endmodule

// File: tb/tb_accum_adder_fifo.sv
// Directed and randomized bench for accum_adder_fifo with a queue-based
// reference model of the result FIFO and accumulator.
module tb_accum_adder_fifo;
    localparam int     WIDTH     = 8;
    localparam int     ACC_WIDTH = 16;
    localparam int     DEPTH     = 4;
    localparam longint WMOD      = 64'd1 << WIDTH;
    localparam longint AMOD      = 64'd1 << ACC_WIDTH;

    typedef struct {
        longint res;
        bit     o;
    } entry_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    entry_t q[$];
    longint m_acc = 0;

    accum_adder_fifo_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .DEPTH(DEPTH)) bus ();

    accum_adder_fifo #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input int av, input int bv, input int md);
        bus.in_valid = v;
        bus.a        = WIDTH'(av);
        bus.b        = WIDTH'(bv);
        bus.mode     = 2'(md);
    endtask

    // Reference entry for an accepted operand pair.
    task automatic model_push(input longint av, input longint bv, input int md);
        entry_t e;
        longint s, t;
        s = av + bv;
        case (md)
            0: begin e.res = s; e.o = (s >= WMOD); end
            1: begin e.res = (s >= WMOD) ? WMOD - 1 : s; e.o = (s >= WMOD); end
            2: begin
                t = m_acc + s;
                e.o = (t >= AMOD);
                m_acc = t % AMOD;
                e.res = m_acc;
            end
            default: begin m_acc = 0; e.res = 0; e.o = 1'b0; end
        endcase
        q.push_back(e);
    endtask

    task automatic check_model();
        chk("count", 64'(bus.count), 64'(q.size()));
        chk("in_ready", 64'(bus.in_ready), 64'(q.size() != DEPTH));
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        chk("acc", 64'(bus.acc), 64'(m_acc));
        if (q.size() != 0) begin
            chk("result", 64'(bus.result), 64'(q[0].res));
            chk("ovf", 64'(bus.ovf), 64'(q[0].o));
        end
    endtask

    // One clock: decide handshakes from the model, clock, update, compare.
    task automatic cycle();
        bit     push, pop, rst;
        longint av, bv;
        int     md;
        push = bus.in_valid && (q.size() != DEPTH);
        pop  = bus.out_ready && (q.size() != 0);
        rst  = !rst_n;
        av   = longint'(bus.a);
        bv   = longint'(bus.b);
        md   = int'(bus.mode);
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_acc = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) model_push(av, bv, md);
        end
        #1;
        check_model();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 0, 0, 0);

        // Reset then idle.
        cycle();
        cycle();
        rst_n = 1'b1;
        chk("rst_acc", 64'(bus.acc), 64'd0);
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_ovf", 64'(bus.ovf), 64'd0);
        cycle();

        // Wrap vs saturate.
        bus.out_ready = 1'b1;
        drive(1'b1, 200, 100, 0);
        cycle();
        chk("wrap_result", 64'(bus.result), 64'd300);
        chk("wrap_ovf", 64'(bus.ovf), 64'd1);
        drive(1'b1, 200, 100, 1);
        cycle();
        chk("sat_result", 64'(bus.result), 64'd255);
        chk("sat_ovf", 64'(bus.ovf), 64'd1);
        drive(1'b1, 3, 4, 0);
        cycle();
        chk("small_result", 64'(bus.result), 64'd7);
        chk("small_ovf", 64'(bus.ovf), 64'd0);
        drive(1'b0, 0, 0, 0);
        cycle();

        // Accumulate and clear.
        drive(1'b1, 10, 5, 2);
        cycle();
        chk("acc_15", 64'(bus.result), 64'd15);
        drive(1'b1, 20, 0, 2);
        cycle();
        chk("acc_35", 64'(bus.result), 64'd35);
        drive(1'b1, 255, 255, 2);
        cycle();
        chk("acc_545", 64'(bus.result), 64'd545);
        drive(1'b1, 0, 0, 3);
        cycle();
        chk("clr_result", 64'(bus.result), 64'd0);
        chk("clr_acc", 64'(bus.acc), 64'd0);

        // Preload acc to 65530, then overflow the accumulator.
        for (int i = 0; i < 128; i++) begin
            drive(1'b1, 255, 255, 2);
            cycle();
        end
        drive(1'b1, 125, 125, 2);
        cycle();
        chk("acc_preload", 64'(bus.acc), 64'd65530);
        drive(1'b1, 5, 5, 2);
        cycle();
        chk("acc_wrap_result", 64'(bus.result), 64'd4);
        chk("acc_wrap_ovf", 64'(bus.ovf), 64'd1);
        drive(1'b0, 0, 0, 0);
        cycle();

        // Backpressure until full, operands changing while stalled.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 10 + i, 20 * i, 0);
            cycle();
        end
        chk("full_count", 64'(bus.count), 64'd4);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        drive(1'b0, 0, 0, 0);
        bus.out_ready = 1'b1;
        cycle();
        chk("first_pop_in_ready", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 3; i++) cycle();
        chk("drained_count", 64'(bus.count), 64'd0);

        // Steady push/pop at count 2, pointers wrapping.
        bus.out_ready = 1'b0;
        drive(1'b1, 1, 2, 0);
        cycle();
        drive(1'b1, 3, 4, 0);
        cycle();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
            cycle();
            chk("steady_count", 64'(bus.count), 64'd2);
        end
        drive(1'b0, 0, 0, 0);
        cycle();
        cycle();

        // Reset mid-operation with count=3 and acc=100.
        bus.out_ready = 1'b0;
        drive(1'b1, 0, 0, 3);
        cycle();
        drive(1'b1, 50, 50, 2);
        cycle();
        drive(1'b1, 7, 9, 0);
        cycle();
        chk("pre_rst_count", 64'(bus.count), 64'd3);
        chk("pre_rst_acc", 64'(bus.acc), 64'd100);
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 99, 99, 2);
        cycle();
        chk("mid_rst_count", 64'(bus.count), 64'd0);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_acc", 64'(bus.acc), 64'd0);
        rst_n = 1'b1;
        drive(1'b1, 11, 22, 0);
        cycle();
        chk("post_rst_result", 64'(bus.result), 64'd33);
        drive(1'b0, 0, 0, 0);
        cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 255),
                  ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2));
            bus.out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/accum_adder_fifo.md
Name: accum_adder_fifo

Overview:
Parametrised successor to the top-level combinational ui_in + uio_in adder. It accepts operand pairs over a valid/ready handshake and applies one of four modes: wrap add, saturating add, running accumulate, or clear. Each result and its overflow flag are buffered in a DEPTH-entry result FIFO, which drains over a second valid/ready handshake. It sits between the pin-level input registers and the uo_out/uio_out drivers in the tile.

Parameters:
WIDTH, 8, operand width in bits (>=2)
ACC_WIDTH, 16, accumulator and result width in bits (must be >= WIDTH+1)
DEPTH, 4, result FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
in_valid  input  1  operand pair and mode are valid
in_ready  output  1  block can accept an operand pair this cycle
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned
mode  input  2  00 wrap add, 01 saturating add, 10 accumulate, 11 clear accumulator
out_valid  output  1  FIFO head holds a result
out_ready  input  1  consumer takes the head this cycle
result  output  ACC_WIDTH  FIFO head result
ovf  output  1  FIFO head overflow flag
count  output  $clog2(DEPTH)+1  current FIFO occupancy
acc  output  ACC_WIDTH  live accumulator value

Behaviour:
- Reset (rst_n low at an edge): acc=0, FIFO emptied, count=0, out_valid=0, result=0, ovf=0, in_ready=1 from the next cycle. Reset wins over any same-cycle handshake. Reset mid-stream discards all buffered results.
- Accept condition: in_valid & in_ready at a rising edge. in_ready = (count != DEPTH). It does not depend on out_ready, so there is no push when full even if a pop happens in the same cycle.
- Pop condition: out_valid & out_ready at a rising edge. out_valid = (count != 0).
- Result computed on accept, with s = a + b at WIDTH+1 bits:
  - mode 00: result = zero-extended s; ovf = s[WIDTH].
  - mode 01: result = s[WIDTH] ? 2^WIDTH-1 : s, zero-extended; ovf = s[WIDTH].
  - mode 10: acc_next = (acc + s) mod 2^ACC_WIDTH; acc <= acc_next; result = acc_next; ovf = 1 iff the ACC_WIDTH+1-bit sum carried out.
  - mode 11: acc <= 0; result = 0; ovf = 0. Still pushes one entry.
- acc changes only on an accepted mode 10 or mode 11 transaction.
- Latency: an entry accepted at edge N is visible on result/ovf with out_valid=1 in the cycle after edge N, provided the FIFO was empty. There is no combinational input-to-output bypass.
- FIFO: circular buffer with wrap-around read/write pointers. Head data (result, ovf) is registered or read from storage and stays stable while out_valid=1 and out_ready=0. result/ovf must not be relied on when out_valid=0.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, order preserved.
- Push when empty with no pop: count goes 0 to 1. Pop of the last entry with no push: out_valid=0 next cycle.
- Changing a, b or mode while in_valid=1 and in_ready=0 is permitted. Only values present at the accepting edge are used.

Test Plan:
- Reset then idle: after rst_n low for 2 cycles -> acc=0, count=0, out_valid=0, in_ready=1.
- Wrap vs saturate (WIDTH=8): push a=200,b=100 with mode 00, then the same with mode 01, out_ready=1 -> results 300 (ovf=1), then 255 (ovf=1). a=3,b=4 mode 00 -> 7, ovf=0.
- Accumulate and clear: mode 10 pairs (10,5), (20,0), (255,255), then mode 11 -> results 15, 35, 545, 0; acc ends 0. Preload acc=65530 with mode 10 (a+b=10) -> result 4, ovf=1.
- Backpressure/full: out_ready=0, push 5 with in_valid held -> 4 accepted, in_ready=0, count=4. Then out_ready=1 -> results drained in push order, in_ready returns 1 the cycle after the first pop.
- Simultaneous push/pop at count=2 over 10 cycles -> count stays 2, output sequence equals input sequence delayed by 2 entries, with pointers wrapping at least twice.
- Reset mid-operation: rst_n low for 1 cycle with count=3 and acc=100 -> next cycle count=0, out_valid=0, acc=0; pre-reset entries never appear.
